// File: rtl/mdu_ctrl_pkg.sv
// Shared multiply/divide unit encodings: command ops and controller states.
// Also imported by the pipeline's control decode so both agree on op values.
package mdu_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// Combinational mult/div datapath: {hi,lo} result for the given op plus a
// divide-by-zero flag. Division works on magnitudes and fixes signs after.
module mdu_ctrl_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] i1,
  input  logic [XLEN-1:0] i2,
  output logic [63:0]     res,
  output logic            dz
);

  logic                 sop;
  logic signed [XLEN:0] a_ext;
  logic signed [XLEN:0] b_ext;
  logic signed [65:0]   prod;
  logic [XLEN-1:0]      ua;
  logic [XLEN-1:0]      ub;
  logic [XLEN-1:0]      q;
  logic [XLEN-1:0]      r;

  always_comb begin
    res   = '0;
    dz    = 1'b0;
    q     = '0;
    r     = '0;
    sop   = is_signed_op(op);
    // A 33-bit extension lets one signed multiplier serve both mult and multu.
    a_ext = {sop & i1[XLEN-1], i1};
    b_ext = {sop & i2[XLEN-1], i2};
    prod  = a_ext * b_ext;
    ua    = (sop && i1[XLEN-1]) ? -i1 : i1;
    ub    = (sop && i2[XLEN-1]) ? -i2 : i2;
    case (op_t'(op))
      MDU_MULT, MDU_MULTU: res = prod[63:0];
      MDU_DIV, MDU_DIVU: begin
        dz = (i2 == '0);
        if (!dz) begin
          q = ua / ub;
          r = ua % ub;
          // Quotient truncates toward zero; remainder follows the dividend.
          if (sop && (i1[XLEN-1] ^ i2[XLEN-1])) q = -q;
          if (sop && i1[XLEN-1]) r = -r;
        end
        res = {r, q};
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: fixed-latency HI/LO commit with busy.
// Optional macro MDU_FLUSH_EN adds a flush input that aborts an in-flight op.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef MDU_FLUSH_EN
  input  logic            flush,
`endif
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] i1,
  input  logic [XLEN-1:0] i2,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_wr;
  logic [63:0]      calc_res;
  logic             calc_dz;
  logic             flush_w;

`ifdef MDU_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  mdu_ctrl_calc u_calc (
    .op  (op),
    .i1  (i1),
    .i2  (i2),
    .res (calc_res),
    .dz  (calc_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush_w) begin
            case (op_t'(op))
              MDU_MULT, MDU_MULTU: begin
                pend    <= calc_res;
                pend_wr <= 1'b1;
                cnt     <= MULT_LD;
                busy    <= 1'b1;
                state   <= S_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                // A zero divisor still occupies the unit but commits nothing.
                pend    <= calc_dz ? '0 : calc_res;
                pend_wr <= !calc_dz;
                cnt     <= DIV_LD;
                busy    <= 1'b1;
                state   <= S_RUN;
              end
              MDU_MTHI: hi <= i1;
              MDU_MTLO: lo <= i1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (flush_w) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
          end else if (cnt == CNT_ONE) begin
            if (pend_wr) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
            state   <= S_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_wr <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the EX stage of the 5-stage pipeline. It sits beside the 32-bit ALU, which stays purely combinational.
- Accepts one mult/div/move-to-HI/LO command per issue and computes the result when the command is accepted.
- Holds the result for a fixed latency, then commits it to the HI/LO registers.
- Exposes `busy` so the hazard unit can stall dependent instructions (mfhi/mflo/mult/div).

Parameters:
- MULT_CYCLES, 5, cycles from accept to HI/LO commit for mult/multu (legal range ≥1).
- DIV_CYCLES, 10, cycles from accept to HI/LO commit for div/divu (legal range ≥1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command valid from EX stage.
- op  in  3  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- i1  in  32  rs operand (forwarded).
- i2  in  32  rt operand (forwarded).
- busy  out  1  high while a mult/div is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, hi=0, lo=0, counter=0, pending registers=0.
- States:
  - IDLE: no operation in flight.
  - RUN: operation in flight.
- Accept rule: command accepted only when state=IDLE and start=1 and op≠0/7. A start in RUN is ignored, because the hazard unit guarantees a stall while busy.
- mult/multu accept:
  - Compute the 64-bit product at accept: mult signed×signed, multu unsigned×unsigned. Latch {HI,LO} into the pending register.
  - Load counter with MULT_CYCLES; go to RUN.
- div/divu accept:
  - Latch LO = quotient and HI = remainder into the pending register. Signed div truncates toward zero; remainder takes the sign of the dividend.
  - Load counter with DIV_CYCLES; go to RUN.
  - Divide by zero (i2=0): no pending write. Go to RUN for DIV_CYCLES anyway; HI/LO unchanged at completion.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: write HI or LO from i1 at the accepting edge. Single cycle; state stays IDLE; busy stays 0.
- busy:
  - Registered output; goes 1 on the accepting edge.
  - Stays 1 through the cycle in which the counter reaches 1.
  - At that edge: hi/lo update from pending, busy→0, state→IDLE.
  - Net effect: busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES); hi/lo show the new value in the first cycle busy=0.
- Back-to-back: a new start is accepted in the same cycle busy first reads 0.
- hi/lo read while busy: show the old values. The consumer must stall.
- Reset mid-operation: the pending result is discarded; all outputs return to reset values immediately.

Optional Feature:
- Macro MDU_FLUSH_EN.
- Defined:
  - Adds input port `flush` (1 bit).
  - flush=1 in RUN: abort next edge; state→IDLE, busy→0, pending discarded, hi/lo unchanged.
  - flush=1 in IDLE: blocks acceptance that cycle.
  - flush has priority over start.
- Not defined: no flush port; every accepted operation runs to completion.

Decomposition:
- Shared include `mdu_defs.v` holds:
  - Op encodings: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - State encodings: S_IDLE, S_RUN.
- Control decode in the pipeline includes the same file.
- One natural sub-module: `mdu_calc`, combinational. Takes op, i1 and i2; produces the 64-bit result and a div-by-zero flag.
- `mdu_ctrl` keeps the FSM, counter, pending register and HI/LO.

Test Plan:
- mult i1=0xFFFFFFFE(−2), i2=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu i1=0xFFFFFFFF, i2=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div i1=−7 (0xFFFFFFF9), i2=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu i1=7, i2=0 → busy 10 cycles, hi/lo unchanged.
- mthi i1=0x12345678 while IDLE → hi=0x12345678 next edge, busy stays 0. Second mult start asserted during busy → ignored; only the first result commits.
- reset pulled low 3 cycles into a div → busy=0, hi=lo=0 asynchronously. After release, mtlo 0xAB → lo=0xAB.
- With MDU_FLUSH_EN: mult 4×4, then flush at cycle 2 → busy drops next edge, hi/lo keep prior values (0/0x10 expected untouched).
